// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and encodings for the multi-cycle processor control path
//
// Purpose: FSM state enum, opcode constants, ALU control codes, ALU operation class codes,
//          immediate format selects, ALU operand selects and result selects, plus a helper that
//          maps an opcode to its immediate format.
// Ports:   none (package)
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operation class handed from the FSM to the ALU decoder.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RD1    = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DATA       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  // Immediate format depends only on the opcode, so it is decoded outside the FSM and stays
  // valid in every state that consumes imm_ext (DECODE, MEMADR, EXECUTEI).
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_BEQ:  sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps FSM operation class and instruction fields to alu_control
//
// Purpose: add/sub requests pass straight through; the funct class decodes funct3, using
//          op[5] and funct7b5 together to tell R-type sub from add (I-type never subtracts).
// Ports:
//   alu_op      in  2  operation class from the FSM (add, sub, funct)
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], 1 for R-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU operation select
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multi-cycle processor
//
// Purpose: sequences fetch/decode/execute/writeback for lw, sw, R-type, I-type ALU, beq and jal,
//          one state per clock, stalling on mem_ready in FETCH, MEMREAD and MEMWRITE. Datapath
//          selects and write enables are Moore outputs of the state register (FETCH additionally
//          qualifies its enables with mem_ready). Optional performance counters are built only
//          when the macro CTRL_PERF_CNT_EN is defined; otherwise both counter ports are 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct3,
//   funct7b5            instruction fields from ir
//   zero                ALU zero flag (beq)
//   mem_ready           memory finished its access this cycle
//   pc_write, adr_src, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, imm_src, alu_control, reg_write   datapath controls
//   illegal             one-cycle pulse for an unsupported opcode in DECODE
//   cycle_cnt           cycles since reset (CNT_WIDTH)
//   instret_cnt         instructions retired (CNT_WIDTH)
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  state_e     state_q;
  state_e     state_d;
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RD2;
    alu_op        = ALU_OP_ADD;

    case (state_q)
      S_FETCH: begin
        // pc+4 goes straight to pc through the alu_result path while ir captures memory.
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALU_RESULT;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // old_pc + imm is captured in alu_out as the beq/jal target.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALU_OUT;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWRITE: begin
        // Write enable is held for the whole wait so slow memory sees a stable request.
        adr_src       = 1'b1;
        result_src    = RES_ALU_OUT;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ALU_OUT;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQ: begin
        // Compare rd1/rd2; the target already sits in alu_out from DECODE.
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_RD2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALU_OUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // pc <= target from alu_out while the ALU forms old_pc+4 as the link value.
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_OUT;
        pc_update  = 1'b1;
        state_d    = S_ALUWB;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imm_src = imm_src_for(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Enables are masked by rst so an interrupted instruction never commits anything.
  assign pc_write  = (pc_update | (branch & zero)) & ~rst;
  assign ir_write  = ir_write_raw & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign illegal   = illegal_raw & ~rst;

`ifdef CTRL_PERF_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] cycle_cnt_q;
  logic [CNT_WIDTH-1:0] instret_cnt_q;

  // Last state of every supported instruction; jal retires through ALUWB.
  assign retire = (state_q == S_MEMWB) ||
                  ((state_q == S_MEMWRITE) && mem_ready) ||
                  (state_q == S_ALUWB) ||
                  (state_q == S_BEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
      if (retire) begin
        instret_cnt_q <= instret_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
